// File: rtl/prefix_add_pkg.sv
// Shared types for the prefix adder and its registered output stage.
package prefix_add_pkg;

   localparam int unsigned ADD_W = 8;

   typedef struct packed {
      logic [ADD_W-1:0] sum;
      logic             cout;
      logic             zero;
      logic             neg;
      logic             ovf;
   } res_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_t;

   // Signed overflow: operands share a sign and the sum's sign differs from it.
   function automatic res_t calc_flags(input logic [ADD_W-1:0] sum,
                                       input logic             cout,
                                       input logic             a_msb,
                                       input logic             b_msb);
      res_t r;
      r.sum  = sum;
      r.cout = cout;
      r.zero = (sum == '0);
      r.neg  = sum[ADD_W-1];
      r.ovf  = (a_msb == b_msb) && (sum[ADD_W-1] != a_msb);
      return r;
   endfunction

endpackage

// File: rtl/prefix_add_out_stage_skid.sv
// Two-entry skid buffer on res_t with a registered in_ready.
module skid_buf2
   import prefix_add_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  res_t in_data,
   output logic out_valid,
   input  logic out_ready,
   output res_t out_data
);

   stage_state_t state, next_state;
   res_t         m, s;
   logic         accept, xfer;
   logic         load_m_in, load_m_s, load_s;

   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;
   assign out_valid = (state != EMPTY);
   assign out_data  = m;

   always_comb begin
      next_state = state;
      load_m_in  = 1'b0;
      load_m_s   = 1'b0;
      load_s     = 1'b0;
      unique case (state)
         EMPTY: if (accept) begin
            load_m_in  = 1'b1;
            next_state = ONE;
         end
         ONE: begin
            if (accept && xfer) begin
               load_m_in = 1'b1;
            end else if (accept) begin
               load_s     = 1'b1;
               next_state = TWO;
            end else if (xfer) begin
               next_state = EMPTY;
            end
         end
         TWO: if (xfer) begin
            load_m_s   = 1'b1;
            next_state = ONE;
         end
         default: next_state = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
         m        <= '0;
         s        <= '0;
      end else begin
         state    <= next_state;
         // Registered ready looks ahead at the next state so it is never late.
         in_ready <= (next_state != TWO);
         if (load_m_in)     m <= in_data;
         else if (load_m_s) m <= s;
         if (load_s)        s <= in_data;
      end
   end

endmodule

// File: rtl/prefix_add_out_stage.sv
// Registered output stage for the 8-bit prefix adder: flags, skid buffer, debug counters.
module prefix_add_out_stage
   import prefix_add_pkg::*;
#(
   parameter int unsigned WIDTH = ADD_W,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic             in_cout,
   input  logic             in_a_msb,
   input  logic             in_b_msb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_ovf,
   output logic             sticky_ovf,
   input  logic             clr,
   output logic [CNT_W-1:0] xfer_cnt
);

   res_t in_res, out_res;
   logic accept, xfer;

   assign in_res = calc_flags(in_sum, in_cout, in_a_msb, in_b_msb);

   skid_buf2 u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_res),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_res)
   );

   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;
   assign out_sum  = out_res.sum;
   assign out_cout = out_res.cout;
   assign out_zero = out_res.zero;
   assign out_neg  = out_res.neg;
   assign out_ovf  = out_res.ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_ovf <= 1'b0;
         xfer_cnt   <= '0;
      end else begin
         if (accept && in_res.ovf) sticky_ovf <= 1'b1;
         else if (clr)             sticky_ovf <= 1'b0;

         if (clr)                          xfer_cnt <= xfer ? CNT_W'(1) : '0;
         else if (xfer && xfer_cnt != '1)  xfer_cnt <= xfer_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_prefix_add_out_stage.sv
// Directed self-checking bench for prefix_add_out_stage.
module tb_prefix_add_out_stage;

   logic        clk, rst;
   logic        in_valid, in_ready, in_cout, in_a_msb, in_b_msb;
   logic [7:0]  in_sum, out_sum;
   logic        out_valid, out_ready, out_cout, out_zero, out_neg, out_ovf;
   logic        sticky_ovf, clr;
   logic [15:0] xfer_cnt;
   int          n_cmp, n_err;

   prefix_add_out_stage #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
      .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
      .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
      .sticky_ovf(sticky_ovf), .clr(clr), .xfer_cnt(xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] sum, input logic c,
                        input logic a, input logic b);
      in_valid = v; in_sum = sum; in_cout = c; in_a_msb = a; in_b_msb = b;
   endtask

   // {valid, sum, cout, zero, neg, ovf}
   function automatic logic [12:0] ent();
      return {out_valid, out_sum, out_cout, out_zero, out_neg, out_ovf};
   endfunction

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; out_ready = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step(); step();
      n_cmp++;
      if (ent() !== 13'h0) begin
         n_err++; $display("FAIL reset_entry: got %h want %h", ent(), 13'h0);
      end
      n_cmp++;
      if ({in_ready, sticky_ovf, xfer_cnt} !== {1'b1, 1'b0, 16'h0}) begin
         n_err++; $display("FAIL reset_ctrl: got %b/%b/%h want 1/0/0000", in_ready, sticky_ovf, xfer_cnt);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_flags();
      out_ready = 1'b1;
      drive(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);   // 0x7F + 0x01
      step();
      n_cmp++;
      if (ent() !== {1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1}) begin
         n_err++; $display("FAIL ovf_neg_entry: got %h want %h", ent(), {1'b1, 8'h80, 4'b0011});
      end
      n_cmp++;
      if (sticky_ovf !== 1'b1) begin
         n_err++; $display("FAIL ovf_sticky: got %b want 1", sticky_ovf);
      end
      drive(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);   // 0xFF + 0x01
      step();
      n_cmp++;
      if (ent() !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL carry_zero_entry: got %h want %h", ent(), {1'b1, 8'h00, 4'b1100});
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      n_cmp++;
      if ({out_valid, xfer_cnt} !== {1'b0, 16'd2}) begin
         n_err++; $display("FAIL flags_drain: got %b/%0d want 0/2", out_valid, xfer_cnt);
      end
      clr = 1'b1; step(); clr = 1'b0;
      n_cmp++;
      if ({sticky_ovf, xfer_cnt} !== {1'b0, 16'd0}) begin
         n_err++; $display("FAIL clr: got %b/%0d want 0/0", sticky_ovf, xfer_cnt);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0); step();
      n_cmp++;
      if ({in_ready, out_valid, out_sum} !== {1'b0, 1'b1, 8'h11}) begin
         n_err++; $display("FAIL bp_full: got %b/%b/%h want 0/1/11", in_ready, out_valid, out_sum);
      end
      drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0); step();
      n_cmp++;
      if ({in_ready, out_valid, out_sum} !== {1'b0, 1'b1, 8'h11}) begin
         n_err++; $display("FAIL bp_hold: got %b/%b/%h want 0/1/11", in_ready, out_valid, out_sum);
      end
      out_ready = 1'b1;
      step();
      n_cmp++;
      if ({in_ready, out_valid, out_sum} !== {1'b1, 1'b1, 8'h22}) begin
         n_err++; $display("FAIL bp_second: got %b/%b/%h want 1/1/22", in_ready, out_valid, out_sum);
      end
      step();
      n_cmp++;
      if ({out_valid, out_sum} !== {1'b1, 8'h33}) begin
         n_err++; $display("FAIL bp_third: got %b/%h want 1/33", out_valid, out_sum);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      n_cmp++;
      if ({out_valid, xfer_cnt} !== {1'b0, 16'd3}) begin
         n_err++; $display("FAIL bp_count: got %b/%0d want 0/3", out_valid, xfer_cnt);
      end
      clr = 1'b1; step(); clr = 1'b0;
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         step();
         n_cmp++;
         if ({in_ready, out_valid, out_sum} !== {1'b1, 1'b1, 8'(i)}) begin
            n_err++; $display("FAIL stream_%0d: got %b/%b/%h want 1/1/%h", i, in_ready, out_valid, out_sum, 8'(i));
         end
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      n_cmp++;
      if ({out_valid, xfer_cnt} !== {1'b0, 16'd10}) begin
         n_err++; $display("FAIL stream_count: got %b/%0d want 0/10", out_valid, xfer_cnt);
      end
   endtask

   task automatic test_simultaneous();
      out_ready = 1'b1;
      drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0); step();
      clr = 1'b1;
      drive(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);   // overflowing accept with clr and a transfer
      step();
      clr = 1'b0;
      n_cmp++;
      if ({sticky_ovf, xfer_cnt} !== {1'b1, 16'd1}) begin
         n_err++; $display("FAIL clr_collide: got %b/%0d want 1/1", sticky_ovf, xfer_cnt);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); step();
      clr = 1'b1; step(); clr = 1'b0;
      drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 65535; k++) step();   // count = k-1 after step k
      n_cmp++;
      if (xfer_cnt !== 16'hFFFE) begin
         n_err++; $display("FAIL cnt_near_sat: got %h want fffe", xfer_cnt);
      end
      step();
      n_cmp++;
      if (xfer_cnt !== 16'hFFFF) begin
         n_err++; $display("FAIL cnt_sat: got %h want ffff", xfer_cnt);
      end
      step(); step();
      n_cmp++;
      if ({out_valid, xfer_cnt} !== {1'b1, 16'hFFFF}) begin
         n_err++; $display("FAIL cnt_no_wrap: got %b/%h want 1/ffff", out_valid, xfer_cnt);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); step();
   endtask

   task automatic test_reset_midop();
      out_ready = 1'b0;
      drive(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0); step();   // overflows: sets sticky
      drive(1'b1, 8'hA2, 1'b0, 1'b1, 1'b1); step();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({in_ready, sticky_ovf, out_sum} !== {1'b0, 1'b1, 8'hA1}) begin
         n_err++; $display("FAIL pre_reset: got %b/%b/%h want 0/1/a1", in_ready, sticky_ovf, out_sum);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, in_ready, sticky_ovf, xfer_cnt} !== {1'b0, 1'b1, 1'b0, 16'h0}) begin
         n_err++; $display("FAIL async_reset: got %b/%b/%b/%h want 0/1/0/0000", out_valid, in_ready, sticky_ovf, xfer_cnt);
      end
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0); step();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({out_valid, out_sum} !== {1'b1, 8'h5A}) begin
         n_err++; $display("FAIL post_reset_first: got %b/%h want 1/5a", out_valid, out_sum);
      end
      step();
      n_cmp++;
      if ({out_valid, xfer_cnt} !== {1'b0, 16'd1}) begin
         n_err++; $display("FAIL post_reset_alone: got %b/%0d want 0/1", out_valid, xfer_cnt);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_flags();
      test_backpressure();
      test_streaming();
      test_simultaneous();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
